dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/mips_pkg.sv | 34 +++
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/arb_sat_counter.sv | 27 ++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS data-memory arbiter: ownership states and datapath widths.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;
  localparam int WAIT_W = 4;
  localparam int BEAT_W = 4;

  // Owner of the memory port in the previous cycle (the registered arbitration state).
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU       = 2'd1,
    DBG       = 2'd2,
    DBG_BURST = 2'd3
  } arb_state_t;

  // One memory-port beat as presented by a requester.
  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] wd;
  } mem_beat_t;

  function automatic mem_beat_t make_beat(input logic we,
                                          input logic [WORD_W-1:0] a,
                                          input logic [WORD_W-1:0] wd);
    mem_beat_t b;
    b.we = we;
    b.a  = a;
    b.wd = wd;
    return b;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MIPS core, the debug/loader port, the arbiter and dmem.
interface dmem_arbiter_if;
  import mips_pkg::*;

  // Handshake: cpu_req/dbg_req are valid; ~cpu_stall/dbg_gnt are ready. A beat
  // transfers in any cycle where both are high; a requester holds its request
  // and payload stable until that cycle.
  logic              cpu_req;
  logic              cpu_we;
  logic [WORD_W-1:0] cpu_a;
  logic [WORD_W-1:0] cpu_wd;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [WORD_W-1:0] dbg_a;
  logic [WORD_W-1:0] dbg_wd;
  logic              dbg_lock;
  logic              dbg_gnt;

  logic              mem_we;
  logic [WORD_W-1:0] mem_a;
  logic [WORD_W-1:0] mem_wd;
  logic [WORD_W-1:0] mem_rd;
  logic [WORD_W-1:0] rd_data;

  logic [CNT_W-1:0]  stall_cnt;

  // Requesters and data memory side.
  modport master (
    output cpu_req, cpu_we, cpu_a, cpu_wd,
    output dbg_req, dbg_we, dbg_a, dbg_wd, dbg_lock,
    output mem_rd,
    input  cpu_stall, dbg_gnt, mem_we, mem_a, mem_wd, rd_data, stall_cnt
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_a, cpu_wd,
    input  dbg_req, dbg_we, dbg_a, dbg_wd, dbg_lock,
    input  mem_rd,
    output cpu_stall, dbg_gnt, mem_we, mem_a, mem_wd, rd_data, stall_cnt
  );

endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with async reset; a clear in the same cycle as an
// increment restarts the count at one.
module arb_sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? ONE_V : '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + ONE_V;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MIPS MEM stage and a debug/loader port.
// Locked debug bursts are compiled in only when DMEM_ARB_BURST_EN is defined.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus,
  output arb_state_t        state,
  output logic [WAIT_W-1:0] wait_cnt
);

  logic      wait_hit;
  logic      burst_cont;
  logic      lock_beat;
  logic      force_dbg;
  logic      cpu_grant;
  logic      debug_grant;
  logic      wait_clr;
  logic      wait_inc;
  mem_beat_t cpu_beat;
  mem_beat_t dbg_beat;
  mem_beat_t win_beat;

  assign wait_hit = (wait_cnt == WAIT_W'(MAX_WAIT));

`ifdef DMEM_ARB_BURST_EN
  logic [BEAT_W-1:0] beat_cnt;

  // A burst keeps debug forced while it is still locked, requesting and short of BURST_MAX.
  assign burst_cont = (state == DBG_BURST) && bus.dbg_req && bus.dbg_lock &&
                      (beat_cnt != BEAT_W'(BURST_MAX));
  assign lock_beat  = bus.dbg_gnt && bus.dbg_lock;

  arb_sat_counter #(
    .W   (BEAT_W),
    .MAX (BURST_MAX)
  ) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (~burst_cont),
    .inc   (lock_beat),
    .cnt   (beat_cnt)
  );
`else
  localparam int unused_burst_max = BURST_MAX;
  logic unused_lock;

  assign unused_lock = bus.dbg_lock;
  assign burst_cont  = 1'b0;
  assign lock_beat   = 1'b0;
`endif

  // force_dbg already implies dbg_req, so a forced cycle with both requests dropped grants nobody.
  assign force_dbg   = (bus.dbg_req && wait_hit) || burst_cont;
  assign cpu_grant   = bus.cpu_req && !force_dbg;
  assign debug_grant = force_dbg || !bus.cpu_req;

  assign bus.cpu_stall = bus.cpu_req & ~cpu_grant;
  assign bus.dbg_gnt   = bus.dbg_req & debug_grant;
  assign bus.rd_data   = bus.mem_rd;

  assign cpu_beat = make_beat(bus.cpu_we, bus.cpu_a, bus.cpu_wd);
  assign dbg_beat = make_beat(bus.dbg_we, bus.dbg_a, bus.dbg_wd);

  always_comb begin
    win_beat = '0;
    if (cpu_grant) begin
      win_beat = cpu_beat;
    end else if (bus.dbg_gnt) begin
      win_beat = dbg_beat;
    end
  end

  // Write enable is gated by reset so a burst interrupted by reset never writes.
  assign bus.mem_we = win_beat.we & ~reset;
  assign bus.mem_a  = win_beat.a;
  assign bus.mem_wd = win_beat.wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (cpu_grant) begin
      state <= CPU;
    end else if (bus.dbg_gnt) begin
      state <= lock_beat ? DBG_BURST : DBG;
    end else begin
      state <= IDLE;
    end
  end

  assign wait_clr = bus.dbg_gnt | ~bus.dbg_req;
  assign wait_inc = bus.dbg_req & ~bus.dbg_gnt;

  arb_sat_counter #(
    .W   (WAIT_W),
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .cnt   (wait_cnt)
  );

  arb_sat_counter #(
    .W   (CNT_W),
    .MAX ((1 << CNT_W) - 1)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (bus.cpu_stall),
    .cnt   (bus.stall_cnt)
  );

endmodule
